ex_wbck_arbiter: RTL

EX_WBCK_ARBITER -- requirements
Module: ex_wbck_arbiter

---
 rtl/ex_wbck_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ex_wbck_arbiter.sv
// rtl/ex_wbck_arbiter.sv - write-back arbiter between the ALU and a buffered long-pipe source
//
// Purpose: picks at most one register-file write per cycle from the ALU
// write-back port or the head of a small FIFO of long-pipe (LSU, mul/div)
// results. The result is registered onto the rf_wbck_* port one cycle
// after the grant.
//
// Ports:
//   clk, rst                          single clock, synchronous active-high reset
//   alu_wbck_valid/ready/idx/dat      ALU write-back handshake and payload
//   lng_wbck_valid/ready/idx/dat      long-pipe write-back handshake and payload
//   rf_wbck_wen/idx/dat               registered register-file write port
//   lbuf_empty, lbuf_full             long-pipe buffer status

module ex_wbck_arbiter #(
    parameter int XLEN       = 32,
    parameter int RFIDX_W    = 5,
    parameter int LBUF_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               alu_wbck_valid,
    output logic               alu_wbck_ready,
    input  logic [RFIDX_W-1:0] alu_wbck_idx,
    input  logic [XLEN-1:0]    alu_wbck_dat,

    input  logic               lng_wbck_valid,
    output logic               lng_wbck_ready,
    input  logic [RFIDX_W-1:0] lng_wbck_idx,
    input  logic [XLEN-1:0]    lng_wbck_dat,

    output logic               rf_wbck_wen,
    output logic [RFIDX_W-1:0] rf_wbck_idx,
    output logic [XLEN-1:0]    rf_wbck_dat,

    output logic               lbuf_empty,
    output logic               lbuf_full
);

    localparam int CNT_W = $clog2(LBUF_DEPTH + 1);
    localparam int PTR_W = (LBUF_DEPTH > 1) ? $clog2(LBUF_DEPTH) : 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(LBUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(LBUF_DEPTH - 1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

    // Long-pipe result buffer
    logic [RFIDX_W-1:0] buf_idx [LBUF_DEPTH];
    logic [XLEN-1:0]    buf_dat [LBUF_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic [STV_W-1:0]   starve_cnt;
    logic               starve_hit;

    logic               push;
    logic               fifo_grant;
    logic               alu_grant;
    logic [RFIDX_W-1:0] gnt_idx;
    logic [XLEN-1:0]    gnt_dat;

    // Status comes from the registered count only, so neither ready has a
    // combinational path from any valid input.
    assign lbuf_empty     = (count == '0);
    assign lbuf_full      = (count == DEPTH_C);
    assign starve_hit     = (starve_cnt == STV_MAX);
    assign lng_wbck_ready = !lbuf_full;
    assign alu_wbck_ready = !(!lbuf_empty && (lbuf_full || starve_hit));

    always_comb begin
        push       = lng_wbck_valid && lng_wbck_ready;
        // The buffer head wins whenever the ALU is idle, the buffer is full,
        // or the ALU has already won STARVE_MAX times in a row.
        fifo_grant = !lbuf_empty && (!alu_wbck_valid || lbuf_full || starve_hit);
        // alu_wbck_ready already excludes every case where fifo_grant would
        // also be asserted together with alu_wbck_valid.
        alu_grant  = alu_wbck_valid && alu_wbck_ready;
        gnt_idx    = alu_wbck_idx;
        gnt_dat    = alu_wbck_dat;
        if (fifo_grant) begin
            gnt_idx = buf_idx[rd_ptr];
            gnt_dat = buf_dat[rd_ptr];
        end
    end

    // Buffer payload storage; contents are don't-care while the count is 0.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_idx[wr_ptr] <= lng_wbck_idx;
            buf_dat[wr_ptr] <= lng_wbck_dat;
        end
    end

    // Buffer pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (fifo_grant) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, fifo_grant})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Counts ALU wins while a long-pipe result is waiting; saturates so the
    // head is forced out on the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (lbuf_empty || fifo_grant) begin
            starve_cnt <= '0;
        end else if (alu_grant && !starve_hit) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Registered register-file write port. A grant to x0 still consumes the
    // source but never raises the write enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wbck_wen <= 1'b0;
            rf_wbck_idx <= '0;
            rf_wbck_dat <= '0;
        end else if (fifo_grant || alu_grant) begin
            rf_wbck_wen <= (gnt_idx != '0);
            rf_wbck_idx <= gnt_idx;
            rf_wbck_dat <= gnt_dat;
        end else begin
            rf_wbck_wen <= 1'b0;
        end
    end

endmodule
